wb_lsu_stage: RTL and testbench
===============================

# wb_lsu_stage

Parametrised writeback stage with an integrated load/store unit for the three-stage RISC-V pipeline. Replaces the fixed single-cycle data-memory path with a valid/ready memory bus handshake, so the stage supports variable-latency memory and back-pressures the execute stage. It adds byte-lane alignment and extension for XLEN 32 or 64, misalignment and bus-timeout exceptions, flush handling, and registered register-file writeback.

## Interface
- XLEN, 32: data width; 32 or 64 only. 64 enables ld/lwu/sd.
- TIMEOUT, 16: maximum cycles spent in REQ+WAIT before an access fault is raised; must be ≥2.
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  execute-stage op present
- in_ready  out  1  stage accepts op this cycle
- flush  in  1  kill in-flight op's side effects on the register file and exceptions
- mem_wr / mem_read  in  1  store / load op
- reg_wr  in  1  op writes rd
- rd  in  5  destination register
- wb_sel  in  2  00 pc+4, 01 alu_o, 10 load data, 11 csr_rdata
- func3  in  3  access size/sign
- alu_o  in  XLEN  result or effective address
- pc  in  XLEN  op PC
- store_data  in  XLEN  unaligned store source
- csr_rdata  in  XLEN  CSR read value
- mem_req  out  1  bus request
- mem_we  out  1  write request
- mem_addr  out  XLEN  address, lane bits zeroed
- mem_be  out  XLEN/8  byte enables
- mem_wdata  out  XLEN  lane-shifted store data
- mem_ready  in  1  request accepted
- mem_rvalid  in  1  load data valid
- mem_rdata  in  XLEN  load data
- rf_we  out  1  register-file write strobe
- rf_waddr  out  5  write address
- rf_wdata  out  XLEN  write data
- exc_valid  out  1  one-cycle exception pulse
- exc_cause  out  4  4 = load misaligned, 5 = load fault, 6 = store misaligned, 7 = store fault
- exc_tval  out  XLEN  faulting address

## Operation
- FSM states: IDLE, REQ, WAIT. in_ready = (state == IDLE). Handshake: in_valid & in_ready.
- Non-memory op accepted: registered writeback next cycle per wb_sel. rf_we = reg_wr & (rd != 0). Stays in IDLE.
- Memory op accepted: latch address, func3, rd, reg_wr and wb_sel; check alignment.
  - Misaligned means a half access with addr[0] set, a word access with addr[1:0] nonzero, or a double access with addr[2:0] nonzero.
  - Misaligned op: exc_valid next cycle with cause 4 or 6 and exc_tval = alu_o. No bus request and no rf write. Stays in IDLE.
- REQ: mem_req=1. mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_ready.
  - On mem_ready, a store returns to IDLE and a load goes to WAIT.
- WAIT: on mem_rvalid, lsu_load_align selects the lane by the address low bits and sign- or zero-extends per func3 (000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu). It then registers the writeback and returns to IDLE.
- Timeout counter: cleared on entering REQ and increments each cycle in REQ or WAIT. On reaching TIMEOUT: exc cause 5 or 7, exc_tval = address, no rf write, return to IDLE.
- mem_rvalid is ignored outside WAIT. rvalid in the same cycle as mem_ready is ignored.
- flush: sets a killed flag for the in-flight op, or kills the op accepted that same cycle. A killed op completes the bus handshake normally but produces no rf_we and no exc_valid. A bus request is never retracted.
- Store lane data: mem_wdata = store_data shifted left by 8 × byte offset. mem_be covers the access bytes.

## Timing
- Reset: state IDLE; mem_req, mem_we, rf_we and exc_valid are 0; all buses 0; counter 0; killed 0.
- Non-memory op: accepted at cycle N, rf_we at N+1. Throughput is 1 per cycle.
- Memory op: accepted at N, mem_req from N+1. mem_ready at M gives WAIT at M+1. mem_rvalid at K gives rf_we and in_ready at K+1.
  - Store: in_ready at M+1.
- Zero-wait memory (ready at N+1, rvalid at N+2): load latency 3 cycles.
- rf_we and exc_valid are single-cycle pulses and mutually exclusive.
- Reset asserted mid-transaction drops mem_req immediately; the bus master resets with it.

## Structure
- Package wb_pkg holds:
  - state enum
  - wb_sel encodings
  - func3 load/store constants
  - exception cause constants
- One combinational sub-module, lsu_load_align, parametrised by XLEN: input rdata, offset and func3; output extended data. The FSM, counter and writeback registers stay in wb_lsu_stage.

## Test plan
- wb_sel=00, pc=0x100, rd=5, reg_wr=1 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x104. The same op with rd=0 gives rf_we=0.
- lb at alu_o=0x1003, mem_rdata=0x80FF_0000, ready/rvalid immediate -> rf_wdata=0xFFFF_FF80, three cycles after accept. lbu at the same address -> 0x0000_0080.
- sh at 0x2002, store_data=0x1234_ABCD -> mem_addr=0x2000, mem_be=1100, mem_wdata=0xABCD_0000. in_ready returns the cycle after mem_ready.
- lw at 0x3001 -> exc_valid next cycle, cause 4, tval 0x3001, mem_req never asserted.
- Load with mem_ready held low for TIMEOUT=16 cycles -> exc cause 5, then IDLE. A late rvalid is ignored and produces no rf_we.
- flush during WAIT with rvalid three cycles later -> handshake completes, no rf_we and no exc_valid, in_ready restored. With XLEN=64, ld at 0x8 returns the full 64-bit data.

Source files
------------

// File: rtl/wb_lsu_stage_pkg.sv
// Shared types and encodings for the writeback / load-store stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Writeback source select
    localparam logic [1:0] WB_PC4  = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_LOAD = 2'b10;
    localparam logic [1:0] WB_CSR  = 2'b11;

    // Load/store func3 encodings; stores use only the two size bits
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Exception causes
    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    // Natural alignment check for a 1/2/4/8-byte access
    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr[0];
            2'b10:   return |addr[1:0];
            default: return |addr[2:0];
        endcase
    endfunction

endpackage

// File: rtl/wb_lsu_stage_lsu_load_align.sv
// Selects the load byte lane by address offset and sign/zero-extends per func3.
// Latency: combinational.
// Backpressure: none.
module lsu_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFFW = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [OFFW-1:0] i_offset,
    input  logic [2:0]      i_func3,
    output logic [XLEN-1:0] o_data
);

    logic [XLEN-1:0] w_shift;

    assign w_shift = i_rdata >> {i_offset, 3'b000};

    // Extend the lane-aligned value to XLEN according to access size and signedness
    always_comb begin
        o_data = w_shift;
        case (i_func3)
            F3_LB:   o_data = XLEN'($signed(w_shift[7:0]));
            F3_LH:   o_data = XLEN'($signed(w_shift[15:0]));
            F3_LW:   o_data = XLEN'($signed(w_shift[31:0]));
            F3_LBU:  o_data = XLEN'(w_shift[7:0]);
            F3_LHU:  o_data = XLEN'(w_shift[15:0]);
            F3_LWU:  o_data = XLEN'(w_shift[31:0]);
            default: o_data = w_shift;
        endcase
    end

endmodule

// File: rtl/wb_lsu_stage.sv
// Writeback stage with valid/ready load-store unit, alignment, timeout and flush.
// Latency: non-memory op 1 cycle; load 3 cycles with zero-wait memory; misaligned exc 1 cycle.
// Backpressure: in_ready low while a bus access is outstanding (REQ/WAIT).
module wb_lsu_stage
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic              i_flush,
    input  logic              i_mem_wr,
    input  logic              i_mem_read,
    input  logic              i_reg_wr,
    input  logic [4:0]        i_rd,
    input  logic [1:0]        i_wb_sel,
    input  logic [2:0]        i_func3,
    input  logic [XLEN-1:0]   i_alu_o,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_store_data,
    input  logic [XLEN-1:0]   i_csr_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN/8-1:0] o_mem_be,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic              i_mem_ready,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata,
    output logic              o_rf_we,
    output logic [4:0]        o_rf_waddr,
    output logic [XLEN-1:0]   o_rf_wdata,
    output logic              o_exc_valid,
    output logic [3:0]        o_exc_cause,
    output logic [XLEN-1:0]   o_exc_tval
);

    localparam int BW   = XLEN / 8;
    localparam int OFFW = $clog2(BW);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    state_t            r_state, w_next;
    logic [XLEN-1:0]   r_addr, r_st_data, r_rf_wdata, r_exc_tval;
    logic [2:0]        r_func3;
    logic [4:0]        r_rd, r_rf_waddr;
    logic [1:0]        r_wb_sel;
    logic              r_reg_wr, r_is_store, r_killed, r_rf_we, r_exc_valid;
    logic [BW-1:0]     r_be;
    logic [CNTW-1:0]   r_cnt;
    logic [3:0]        r_exc_cause;

    logic              w_accept, w_is_mem, w_misalign, w_timeout, w_killed;
    logic [OFFW-1:0]   w_offset;
    logic [BW-1:0]     w_be_base, w_be;
    logic [XLEN-1:0]   w_st_data, w_load_data, w_nonmem_data;

    assign w_accept   = i_in_valid & o_in_ready;
    assign w_is_mem   = i_mem_wr | i_mem_read;
    assign w_misalign = is_misaligned(i_func3[1:0], i_alu_o[2:0]);
    assign w_offset   = i_alu_o[OFFW-1:0];
    assign w_be       = w_be_base << w_offset;
    assign w_st_data  = i_store_data << {w_offset, 3'b000};
    assign w_timeout  = (r_cnt == CNTW'(TIMEOUT - 1));
    // A flush arriving in the completing cycle still kills that op
    assign w_killed   = r_killed | i_flush;

    // Byte-enable pattern for the access size, before lane shift
    always_comb begin
        case (i_func3[1:0])
            2'b00:   w_be_base = BW'(1);
            2'b01:   w_be_base = BW'(2'b11);
            2'b10:   w_be_base = BW'(4'hF);
            default: w_be_base = '1;
        endcase
    end

    // Writeback value for ops that do not touch memory
    always_comb begin
        case (i_wb_sel)
            WB_PC4:  w_nonmem_data = i_pc + XLEN'(4);
            WB_ALU:  w_nonmem_data = i_alu_o;
            WB_CSR:  w_nonmem_data = i_csr_rdata;
            default: w_nonmem_data = '0;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata  (i_mem_rdata),
        .i_offset (r_addr[OFFW-1:0]),
        .i_func3  (r_func3),
        .o_data   (w_load_data)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // FSM next state; a completed handshake takes priority over timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept && w_is_mem && !w_misalign) w_next = ST_REQ;
            ST_REQ: begin
                if (i_mem_ready)    w_next = r_is_store ? ST_IDLE : ST_WAIT;
                else if (w_timeout) w_next = ST_IDLE;
            end
            ST_WAIT: if (i_mem_rvalid || w_timeout) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM outputs: bus request strobes and upstream ready
    always_comb begin
        o_in_ready = (r_state == ST_IDLE);
        o_mem_req  = (r_state == ST_REQ);
        o_mem_we   = (r_state == ST_REQ) && r_is_store;
    end

    assign o_mem_addr  = {r_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign o_mem_be    = r_be;
    assign o_mem_wdata = r_st_data;
    assign o_rf_we     = r_rf_we;
    assign o_rf_waddr  = r_rf_waddr;
    assign o_rf_wdata  = r_rf_wdata;
    assign o_exc_valid = r_exc_valid;
    assign o_exc_cause = r_exc_cause;
    assign o_exc_tval  = r_exc_tval;

    // Op latching, timeout counter, kill flag and registered writeback/exception pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0; r_st_data <= '0; r_be <= '0; r_func3 <= '0;
            r_rd <= '0; r_wb_sel <= '0; r_reg_wr <= 1'b0; r_is_store <= 1'b0;
            r_killed <= 1'b0; r_cnt <= '0;
            r_rf_we <= 1'b0; r_rf_waddr <= '0; r_rf_wdata <= '0;
            r_exc_valid <= 1'b0; r_exc_cause <= '0; r_exc_tval <= '0;
        end else begin
            r_rf_we     <= 1'b0;
            r_exc_valid <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_accept) begin
                    if (w_is_mem) begin
                        r_addr     <= i_alu_o;
                        r_st_data  <= w_st_data;
                        r_be       <= w_be;
                        r_func3    <= i_func3;
                        r_rd       <= i_rd;
                        r_wb_sel   <= i_wb_sel;
                        r_reg_wr   <= i_reg_wr;
                        r_is_store <= i_mem_wr;
                        r_killed   <= i_flush;
                        r_cnt      <= '0;
                        if (w_misalign) begin
                            r_exc_valid <= !i_flush;
                            r_exc_cause <= i_mem_wr ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                            r_exc_tval  <= i_alu_o;
                        end
                    end else begin
                        r_rf_we    <= i_reg_wr && (i_rd != 5'd0) && !i_flush;
                        r_rf_waddr <= i_rd;
                        r_rf_wdata <= w_nonmem_data;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    r_cnt    <= r_cnt + CNTW'(1);
                    r_killed <= w_killed;
                    if (r_state == ST_WAIT && i_mem_rvalid) begin
                        // Load data is written only when the op selected it as its result
                        r_rf_we    <= r_reg_wr && (r_rd != 5'd0) && !w_killed && (r_wb_sel == WB_LOAD);
                        r_rf_waddr <= r_rd;
                        r_rf_wdata <= w_load_data;
                    end else if (!(r_state == ST_REQ && i_mem_ready) && w_timeout) begin
                        r_exc_valid <= !w_killed;
                        r_exc_cause <= r_is_store ? EXC_ST_FAULT : EXC_LD_FAULT;
                        r_exc_tval  <= r_addr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_lsu_stage.sv
// Directed bench for wb_lsu_stage: XLEN=32 instance for most vectors, XLEN=64 for ld/lwu/lw.
// Latency: n/a.
// Backpressure: memory ready/rvalid driven by the bench.
module tb_wb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, mem_wr, mem_read, reg_wr;
    logic [4:0]  rd;
    logic [1:0]  wb_sel;
    logic [2:0]  func3;

    // XLEN=32 instance
    logic        in_valid, mem_ready, mem_rvalid;
    logic [31:0] alu_o, pc, store_data, csr_rdata, mem_rdata;
    logic        in_ready, mem_req, mem_we, rf_we, exc_valid;
    logic [31:0] mem_addr, mem_wdata, rf_wdata, exc_tval;
    logic [3:0]  mem_be, exc_cause;
    logic [4:0]  rf_waddr;

    // XLEN=64 instance
    logic        in_valid64, mem_ready64, mem_rvalid64;
    logic [63:0] alu_o64, pc64, store_data64, csr_rdata64, mem_rdata64;
    logic        in_ready64, mem_req64, mem_we64, rf_we64, exc_valid64;
    logic [63:0] mem_addr64, mem_wdata64, rf_wdata64, exc_tval64;
    logic [7:0]  mem_be64;
    logic [3:0]  exc_cause64;
    logic [4:0]  rf_waddr64;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wb_lsu_stage #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready), .i_flush(flush),
        .i_mem_wr(mem_wr), .i_mem_read(mem_read), .i_reg_wr(reg_wr), .i_rd(rd), .i_wb_sel(wb_sel),
        .i_func3(func3), .i_alu_o(alu_o), .i_pc(pc), .i_store_data(store_data),
        .i_csr_rdata(csr_rdata), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_be(mem_be), .o_mem_wdata(mem_wdata), .i_mem_ready(mem_ready),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata), .o_rf_we(rf_we),
        .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata), .o_exc_valid(exc_valid),
        .o_exc_cause(exc_cause), .o_exc_tval(exc_tval)
    );

    wb_lsu_stage #(.XLEN(64), .TIMEOUT(16)) dut64 (
        .clk(clk), .rst(rst), .i_in_valid(in_valid64), .o_in_ready(in_ready64), .i_flush(flush),
        .i_mem_wr(mem_wr), .i_mem_read(mem_read), .i_reg_wr(reg_wr), .i_rd(rd), .i_wb_sel(wb_sel),
        .i_func3(func3), .i_alu_o(alu_o64), .i_pc(pc64), .i_store_data(store_data64),
        .i_csr_rdata(csr_rdata64), .o_mem_req(mem_req64), .o_mem_we(mem_we64),
        .o_mem_addr(mem_addr64), .o_mem_be(mem_be64), .o_mem_wdata(mem_wdata64),
        .i_mem_ready(mem_ready64), .i_mem_rvalid(mem_rvalid64), .i_mem_rdata(mem_rdata64),
        .o_rf_we(rf_we64), .o_rf_waddr(rf_waddr64), .o_rf_wdata(rf_wdata64),
        .o_exc_valid(exc_valid64), .o_exc_cause(exc_cause64), .o_exc_tval(exc_tval64)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one op to the 32-bit stage for a single accepting edge
    task automatic issue(input logic wr, input logic rdn, input logic rw, input logic [4:0] d,
                         input logic [1:0] sel, input logic [2:0] f3, input logic [31:0] a);
        mem_wr = wr; mem_read = rdn; reg_wr = rw; rd = d; wb_sel = sel; func3 = f3; alu_o = a;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; mem_wr = 1'b0; mem_read = 1'b0; reg_wr = 1'b0;
    endtask

    // Zero-wait load on the 32-bit stage: ready at N+1, rvalid at N+2, writeback at N+3
    task automatic run_load32(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] rdata, input logic [31:0] exp);
        issue(1'b0, 1'b1, 1'b1, 5'd7, 2'b10, f3, a);
        chk({tag, "_req"}, 64'(mem_req), 64'd1);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(a & 32'hFFFF_FFFC));
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
        chk({tag, "_nowb_early"}, 64'(rf_we), 64'd0);
        tick();
        mem_rvalid = 1'b0;
        chk({tag, "_we"}, 64'(rf_we), 64'd1);
        chk({tag, "_waddr"}, 64'(rf_waddr), 64'd7);
        chk({tag, "_data"}, 64'(rf_wdata), 64'(exp));
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_load64(input string tag, input logic [2:0] f3, input logic [63:0] a,
                              input logic [63:0] rdata, input logic [63:0] exp,
                              input logic [7:0] exp_be);
        mem_read = 1'b1; reg_wr = 1'b1; rd = 5'd3; wb_sel = 2'b10; func3 = f3; alu_o64 = a;
        in_valid64 = 1'b1;
        tick();
        in_valid64 = 1'b0; mem_read = 1'b0; reg_wr = 1'b0;
        chk({tag, "_addr"}, mem_addr64, a & 64'hFFFF_FFFF_FFFF_FFF8);
        chk({tag, "_be"}, 64'(mem_be64), 64'(exp_be));
        mem_ready64 = 1'b1;
        tick();
        mem_ready64 = 1'b0; mem_rvalid64 = 1'b1; mem_rdata64 = rdata;
        tick();
        mem_rvalid64 = 1'b0;
        chk({tag, "_we"}, 64'(rf_we64), 64'd1);
        chk({tag, "_data"}, rf_wdata64, exp);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; mem_wr = 1'b0; mem_read = 1'b0; reg_wr = 1'b0;
        rd = '0; wb_sel = '0; func3 = '0;
        in_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        alu_o = '0; pc = '0; store_data = '0; csr_rdata = '0; mem_rdata = '0;
        in_valid64 = 1'b0; mem_ready64 = 1'b0; mem_rvalid64 = 1'b0;
        alu_o64 = '0; pc64 = '0; store_data64 = '0; csr_rdata64 = '0; mem_rdata64 = '0;

        // Asynchronous reset, observed before the first clock edge
        #2 rst = 1'b1;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_exc_valid", 64'(exc_valid), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Non-memory writebacks, back to back
        pc = 32'h100;
        issue(1'b0, 1'b0, 1'b1, 5'd5, 2'b00, 3'b000, 32'h0);
        chk("pc4_we", 64'(rf_we), 64'd1);
        chk("pc4_waddr", 64'(rf_waddr), 64'd5);
        chk("pc4_data", 64'(rf_wdata), 64'h104);
        chk("pc4_in_ready", 64'(in_ready), 64'd1);
        issue(1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 3'b000, 32'h0);
        chk("rd0_no_we", 64'(rf_we), 64'd0);
        issue(1'b0, 1'b0, 1'b1, 5'd3, 2'b01, 3'b000, 32'hDEAD_BEEF);
        chk("alu_data", 64'(rf_wdata), 64'hDEAD_BEEF);
        chk("alu_we", 64'(rf_we), 64'd1);
        csr_rdata = 32'hCAFE_0001;
        issue(1'b0, 1'b0, 1'b1, 5'd4, 2'b11, 3'b000, 32'h0);
        chk("csr_data", 64'(rf_wdata), 64'hCAFE_0001);
        flush = 1'b1;
        issue(1'b0, 1'b0, 1'b1, 5'd6, 2'b01, 3'b000, 32'h55);
        flush = 1'b0;
        chk("flush_accept_no_we", 64'(rf_we), 64'd0);
        tick();

        // Loads: lane select and extension
        run_load32("lb",  3'b000, 32'h1003, 32'h80FF_0000, 32'hFFFF_FF80);
        run_load32("lbu", 3'b100, 32'h1003, 32'h80FF_0000, 32'h0000_0080);
        run_load32("lh",  3'b001, 32'h1002, 32'h80FF_0000, 32'hFFFF_80FF);
        run_load32("lhu", 3'b101, 32'h1002, 32'h80FF_0000, 32'h0000_80FF);
        run_load32("lw",  3'b010, 32'h1004, 32'h80FF_0000, 32'h80FF_0000);

        // sh at 0x2002 with one wait cycle before mem_ready
        store_data = 32'h1234_ABCD;
        issue(1'b1, 1'b0, 1'b0, 5'd0, 2'b01, 3'b001, 32'h2002);
        chk("sh_req", 64'(mem_req), 64'd1);
        chk("sh_we", 64'(mem_we), 64'd1);
        chk("sh_addr", 64'(mem_addr), 64'h2000);
        chk("sh_be", 64'(mem_be), 64'b1100);
        chk("sh_wdata", 64'(mem_wdata), 64'hABCD_0000);
        chk("sh_busy", 64'(in_ready), 64'd0);
        tick();
        chk("sh_hold_addr", 64'(mem_addr), 64'h2000);
        chk("sh_hold_req", 64'(mem_req), 64'd1);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("sh_in_ready", 64'(in_ready), 64'd1);
        chk("sh_req_drop", 64'(mem_req), 64'd0);
        chk("sh_no_rf", 64'(rf_we), 64'd0);
        store_data = 32'h0000_00EF;
        issue(1'b1, 1'b0, 1'b0, 5'd0, 2'b01, 3'b000, 32'h2001);
        chk("sb_be", 64'(mem_be), 64'b0010);
        chk("sb_wdata", 64'(mem_wdata), 64'h0000_EF00);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;

        // Misaligned accesses
        issue(1'b0, 1'b1, 1'b1, 5'd7, 2'b10, 3'b010, 32'h3001);
        chk("lw_mis_exc", 64'(exc_valid), 64'd1);
        chk("lw_mis_cause", 64'(exc_cause), 64'd4);
        chk("lw_mis_tval", 64'(exc_tval), 64'h3001);
        chk("lw_mis_noreq", 64'(mem_req), 64'd0);
        chk("lw_mis_norf", 64'(rf_we), 64'd0);
        tick();
        chk("lw_mis_pulse", 64'(exc_valid), 64'd0);
        chk("lw_mis_noreq2", 64'(mem_req), 64'd0);
        issue(1'b1, 1'b0, 1'b0, 5'd0, 2'b01, 3'b001, 32'h3003);
        chk("sh_mis_cause", 64'(exc_cause), 64'd6);
        chk("sh_mis_exc", 64'(exc_valid), 64'd1);
        tick();

        // Load timeout with mem_ready held low
        issue(1'b0, 1'b1, 1'b1, 5'd7, 2'b10, 3'b010, 32'h4000);
        repeat (15) tick();
        chk("to_still_req", 64'(mem_req), 64'd1);
        chk("to_no_exc_yet", 64'(exc_valid), 64'd0);
        tick();
        chk("to_exc", 64'(exc_valid), 64'd1);
        chk("to_cause", 64'(exc_cause), 64'd5);
        chk("to_tval", 64'(exc_tval), 64'h4000);
        chk("to_idle", 64'(in_ready), 64'd1);
        chk("to_req_drop", 64'(mem_req), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_rvalid = 1'b0;
        chk("to_late_rvalid", 64'(rf_we), 64'd0);

        // Flush while waiting for load data
        issue(1'b0, 1'b1, 1'b1, 5'd9, 2'b10, 3'b010, 32'h5000);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        chk("fl_busy", 64'(in_ready), 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h2222_2222;
        tick();
        mem_rvalid = 1'b0;
        chk("fl_no_we", 64'(rf_we), 64'd0);
        chk("fl_no_exc", 64'(exc_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);

        // After a kill, the next load writes back normally
        run_load32("post_fl", 3'b010, 32'h5008, 32'h3333_4444, 32'h3333_4444);

        // XLEN=64 accesses
        run_load64("ld",  3'b011, 64'h8, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'hFF);
        run_load64("lwu", 3'b110, 64'hC, 64'h89AB_CDEF_0123_4567, 64'h0000_0000_89AB_CDEF, 8'hF0);
        run_load64("lw64", 3'b010, 64'hC, 64'h89AB_CDEF_0123_4567, 64'hFFFF_FFFF_89AB_CDEF, 8'hF0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
